reg_scoreboard: RTL
===================

# reg_scoreboard

Register-dependency scoreboard for the femtoRV32 pipeline. It sits between the issue/decode stage and the register file's write-back port. It counts outstanding writes per architectural register, stalls any instruction whose sources or destination are still pending, and retires pending writes as results reach the register file. It is the writer-side tracking counterpart to the register file's read path.

## Interface

Parameters:
- CNT_W, 2: width of each per-register pending-write counter; max outstanding writes per register is 2^CNT_W-1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- issue_valid  input  1  decode presents an instruction this cycle
- issue_rs1  input  5  source register 1
- issue_rs2  input  5  source register 2
- issue_uses_rs1  input  1  instruction reads rs1
- issue_uses_rs2  input  1  instruction reads rs2
- issue_rd  input  5  destination register
- issue_writes_rd  input  1  instruction writes rd
- issue_stall  output  1  instruction must be held; combinational from current state and issue inputs
- issue_accept  output  1  issue_valid && !issue_stall
- wb_valid  input  1  a result is written to the register file this cycle (mirrors regWrite)
- wb_rd  input  5  register being written back
- flush  input  1  synchronous clear of all pending state (branch mispredict/trap)
- busy_vec  output  32  bit i = 1 when register i has a pending count greater than 0; bit 0 is always 0
- pending_total  output  CNT_W+5  sum of all per-register counters
- err_underflow  output  1  sticky: a write-back arrived for a register with a count of 0

## Operation

- State: 31 counters cnt[1..31] of CNT_W bits, one registered pending_total, one sticky err_underflow. No state for x0.
- Hazard terms, all computed from registered state only:
  - raw1 = issue_uses_rs1 && rs1!=0 && cnt[rs1]!=0
  - raw2 = the same test for rs2
  - sat = issue_writes_rd && rd!=0 && cnt[rd]==max
- issue_stall = issue_valid && (raw1 || raw2 || sat). WAW is allowed up to the counter limit.
- inc = issue_accept && issue_writes_rd && rd!=0.
- dec = wb_valid && wb_rd!=0 && cnt[wb_rd]!=0.
- Per-register next value:
  - +1 if that register receives inc only.
  - −1 if it receives dec only.
  - Unchanged if it receives both in the same cycle, or neither.
- Write-back with wb_rd!=0 and cnt==0: counter is left at 0 and err_underflow is set. The flag clears only on reset.
- wb_rd==0, or issue_rd==0: ignored. No count change, no error.
- flush = 1: all counters and pending_total go to 0 on the next edge, overriding inc and dec in that cycle. issue_accept in a flush cycle is not counted. err_underflow is unaffected.
- pending_total tracks the counter changes: +inc −dec, with the same flush override.

## Timing

- Reset (rst=0, asynchronous): all counters = 0, pending_total = 0, err_underflow = 0, busy_vec = 0. Combinationally, issue_stall = 0 and issue_accept = issue_valid.
- Reset deassertion mid-operation discards all pending state. Write-backs that arrive afterwards for pre-reset issues raise err_underflow.
- Issue latency: an accepted write to rd in cycle N makes busy_vec[rd] = 1 from cycle N+1. An issue in cycle N+1 reading rd stalls.
- Write-back latency: no bypass. A write-back in cycle N clears the hazard in N+1. A dependent instruction waiting in cycle N still stalls in N and accepts in N+1.
- Same-cycle issue and write-back to the same rd: the count is unchanged. Stall for that cycle uses the pre-edge count.
- Counter saturation: at cnt==max, a further write to that rd stalls until a write-back decrements it. The counter never wraps.
- issue_stall and issue_accept have zero-cycle latency from the issue inputs. They do not depend on wb_valid or flush.

## Test plan

- Reset: hold rst=0 while driving issue_valid=1 writing rd=5 → busy_vec=0, pending_total=0, err_underflow=0, issue_accept=1 with no count change. Release rst → the next accepted write to rd=5 gives busy_vec=32'h20 the following cycle.
- RAW stall: issue write to x3 in cycle 0. In cycle 1, issue reading rs1=x3 → issue_stall=1. Write-back x3 in cycle 4 → stall stays 1 in cycle 4, issue_accept=1 in cycle 5, busy_vec[3]=0.
- x0 handling: issue rd=0 and rs1=rs2=0 repeatedly, plus wb_rd=0 → never stalls, busy_vec=0, pending_total=0, err_underflow=0.
- WAW and saturation (CNT_W=2): three writes to x7 accepted, fourth stalls (sat). Issue and write-back to x7 in the same cycle → count stays 3. Three write-backs → busy_vec[7]=0, pending_total=0.
- Flush priority: pending writes to x1, x2, x9 (pending_total=3). Assert flush together with an accepted write to x4 and a write-back of x1 → next cycle busy_vec=0, pending_total=0.
- Underflow: write-back x12 with no pending write → err_underflow=1 and stays 1 through flush. It clears only on rst=0.

Source files
------------

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write scoreboard for issue hazard stalls
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rs1,
    input  logic [4:0]         issue_rs2,
    input  logic               issue_uses_rs1,
    input  logic               issue_uses_rs2,
    input  logic [4:0]         issue_rd,
    input  logic               issue_writes_rd,
    output logic               issue_stall,
    output logic               issue_accept,
    input  logic               wb_valid,
    input  logic [4:0]         wb_rd,
    input  logic               flush,
    output logic [31:0]        busy_vec,
    output logic [CNT_W+4:0]   pending_total,
    output logic               err_underflow
);
    localparam int TOT_W = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [1:31];
    logic [CNT_W-1:0] cnt_d [1:31];
    logic [TOT_W-1:0] pending_total_q, pending_total_d;
    logic             err_underflow_q, err_underflow_d;

    // x0 reads as a permanently idle counter so hazard lookups need no special index range
    logic [CNT_W-1:0] cnt_view [0:31];
    always_comb begin
        cnt_view[0] = '0;
        for (int i = 1; i < 32; i++) cnt_view[i] = cnt_q[i];
    end

    logic raw1, raw2, sat, inc, wb_nz, dec, underflow;

    always_comb begin
        raw1      = issue_uses_rs1 && (issue_rs1 != 5'd0) && (cnt_view[issue_rs1] != '0);
        raw2      = issue_uses_rs2 && (issue_rs2 != 5'd0) && (cnt_view[issue_rs2] != '0);
        sat       = issue_writes_rd && (issue_rd != 5'd0) && (cnt_view[issue_rd] == CNT_MAX);
        issue_stall  = issue_valid && (raw1 || raw2 || sat);
        issue_accept = issue_valid && !issue_stall;
        inc       = issue_accept && issue_writes_rd && (issue_rd != 5'd0);
        wb_nz     = wb_valid && (wb_rd != 5'd0);
        dec       = wb_nz && (cnt_view[wb_rd] != '0);
        underflow = wb_nz && (cnt_view[wb_rd] == '0);
    end

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (inc && (issue_rd == 5'(i)) && !(dec && (wb_rd == 5'(i)))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && (wb_rd == 5'(i)) && !(inc && (issue_rd == 5'(i)))) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        pending_total_d = flush ? '0 : (pending_total_q + TOT_W'(inc) - TOT_W'(dec));
        err_underflow_d = err_underflow_q | underflow;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) cnt_q[i] <= '0;
            pending_total_q <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) cnt_q[i] <= cnt_d[i];
            pending_total_q <= pending_total_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    always_comb begin
        busy_vec[0] = 1'b0;
        for (int i = 1; i < 32; i++) busy_vec[i] = (cnt_q[i] != '0);
    end

    assign pending_total = pending_total_q;
    assign err_underflow = err_underflow_q;
endmodule
